// File: rtl/ped_pkg.sv
// rtl/ped_pkg.sv - shared types and constants for the pedestrian crossing controller
// Contents:
//   ped_state_t   crossing phase (DONT_WALK, WALK, CLEAR)
//   LIGHT_*       vehicle light codes {red,yellow,green}
//   TIMER_W       width of the phase timer and countdown display
//   lights_legal  true when the vehicle lights vector is exactly one-hot
package ped_pkg;

    typedef enum logic [1:0] {
        DONT_WALK = 2'b00,
        WALK      = 2'b01,
        CLEAR     = 2'b10
    } ped_state_t;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    localparam int TIMER_W = 4;

    function automatic logic lights_legal(input logic [2:0] l);
        return (l == LIGHT_RED) || (l == LIGHT_YELLOW) || (l == LIGHT_GREEN);
    endfunction

endpackage

// File: rtl/ped_crossing_ctrl_if.sv
// rtl/ped_crossing_ctrl_if.sv - signal bundle between the crossing controller and its environment
// Signals:
//   tick        timing-enable pulse, one clock wide
//   lights      vehicle lights {red,yellow,green}
//   ped_btn     raw asynchronous push-button, active-high
//   walk        WALK lamp
//   dont_walk   DONT WALK lamp (steady or flashing)
//   countdown   remaining CLEAR ticks, 0 outside CLEAR
//   req_pending latched, not-yet-served request
//   fault       sticky illegal-lights indicator
//   chirp       audible cue pulse
// Modports: master drives the inputs of the controller, slave is the controller.
interface ped_crossing_ctrl_if;
    import ped_pkg::*;

    logic               tick;
    logic [2:0]         lights;
    logic               ped_btn;
    logic               walk;
    logic               dont_walk;
    logic [TIMER_W-1:0] countdown;
    logic               req_pending;
    logic               fault;
    logic               chirp;

    modport master (
        output tick, lights, ped_btn,
        input  walk, dont_walk, countdown, req_pending, fault, chirp
    );

    modport slave (
        input  tick, lights, ped_btn,
        output walk, dont_walk, countdown, req_pending, fault, chirp
    );

endinterface

// File: rtl/ped_btn_debounce.sv
// rtl/ped_btn_debounce.sv - push-button synchroniser and debouncer with a rise pulse
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   btn_raw  in   raw asynchronous button level
//   rise     out  one-clock pulse when the debounced level goes 0->1
// The debounced level follows the synchronised level only after it has
// differed for DEBOUNCE_CYCLES consecutive clocks.
module ped_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic rise
);

    localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_CYCLES - 1);

    logic       sync1;
    logic       sync2;
    logic       stable;
    logic [3:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            rise   <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt    <= '0;
                stable <= sync2;
                rise   <= sync2;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/ped_crossing_ctrl.sv
// rtl/ped_crossing_ctrl.sv - pedestrian crossing controller slaved to vehicle light phases
// Ports:
//   clk   in  system clock
//   rst   in  asynchronous active-high reset
//   bus   ped_crossing_ctrl_if.slave: tick, lights, ped_btn in;
//         walk, dont_walk, countdown, req_pending, fault, chirp out
// Build option: define PED_ACCESSIBLE_EN to enable the audible chirp cue;
// otherwise chirp is tied low.
module ped_crossing_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WALK_TICKS      = 4,
    parameter int CLEAR_TICKS     = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    ped_crossing_ctrl_if.slave   bus
);
    import ped_pkg::*;

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15 ||
        WALK_TICKS < 1 || WALK_TICKS > 15 ||
        CLEAR_TICKS < 1 || CLEAR_TICKS > 15) begin : g_bad_param
        $error("ped_crossing_ctrl: parameters must be in 1..15");
    end

    localparam logic [TIMER_W-1:0] WALK_INIT  = TIMER_W'(WALK_TICKS);
    localparam logic [TIMER_W-1:0] CLEAR_INIT = TIMER_W'(CLEAR_TICKS);
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

    logic btn_rise;

    ped_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (bus.ped_btn),
        .rise    (btn_rise)
    );

    logic is_red;
    logic red_edge;
    logic illegal;

    ped_state_t         state;
    logic [TIMER_W-1:0] timer;
    logic               flash_phase;
    logic               prev_red;
    logic               walk_q;
    logic               dont_walk_q;
    logic [TIMER_W-1:0] countdown_q;
    logic               req_q;
    logic               fault_q;
`ifdef PED_ACCESSIBLE_EN
    logic               chirp_q;
`endif

    assign is_red   = (bus.lights == LIGHT_RED);
    assign red_edge = is_red & ~prev_red;
    assign illegal  = ~lights_legal(bus.lights);

    // prev_red resets to 1 so lights already red at reset release do not
    // look like a fresh red entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= DONT_WALK;
            timer       <= '0;
            flash_phase <= 1'b0;
            prev_red    <= 1'b1;
            walk_q      <= 1'b0;
            dont_walk_q <= 1'b1;
            countdown_q <= '0;
            req_q       <= 1'b0;
            fault_q     <= 1'b0;
`ifdef PED_ACCESSIBLE_EN
            chirp_q     <= 1'b0;
`endif
        end else begin
            prev_red <= is_red;
`ifdef PED_ACCESSIBLE_EN
            chirp_q  <= 1'b0;
`endif
            if (illegal || fault_q) begin
                // Sticky fault: hold steady DONT WALK and never grant again;
                // requests still latch so the display reflects the press.
                fault_q     <= 1'b1;
                state       <= DONT_WALK;
                timer       <= '0;
                flash_phase <= 1'b0;
                walk_q      <= 1'b0;
                dont_walk_q <= 1'b1;
                countdown_q <= '0;
                if (btn_rise) req_q <= 1'b1;
            end else begin
                case (state)
                    DONT_WALK: begin
                        walk_q      <= 1'b0;
                        dont_walk_q <= 1'b1;
                        countdown_q <= '0;
                        // A press arriving with the grant is served by it.
                        if (red_edge && req_q) begin
                            state       <= WALK;
                            timer       <= WALK_INIT;
                            req_q       <= 1'b0;
                            walk_q      <= 1'b1;
                            dont_walk_q <= 1'b0;
                        end else if (btn_rise) begin
                            req_q <= 1'b1;
                        end
                    end

                    WALK: begin
                        // Presses during WALK are intentionally dropped.
                        if (!is_red) begin
                            state       <= DONT_WALK;
                            walk_q      <= 1'b0;
                            dont_walk_q <= 1'b1;
                            countdown_q <= '0;
                        end else if (bus.tick) begin
`ifdef PED_ACCESSIBLE_EN
                            chirp_q <= 1'b1;
`endif
                            if (timer == TIMER_ONE) begin
                                state       <= CLEAR;
                                timer       <= CLEAR_INIT;
                                countdown_q <= CLEAR_INIT;
                                flash_phase <= 1'b1;
                                walk_q      <= 1'b0;
                                dont_walk_q <= 1'b1;
                            end else begin
                                timer <= timer - TIMER_ONE;
                            end
                        end
                    end

                    CLEAR: begin
                        if (btn_rise) req_q <= 1'b1;
                        if (!is_red) begin
                            state       <= DONT_WALK;
                            flash_phase <= 1'b0;
                            walk_q      <= 1'b0;
                            dont_walk_q <= 1'b1;
                            countdown_q <= '0;
                        end else if (bus.tick) begin
`ifdef PED_ACCESSIBLE_EN
                            chirp_q <= flash_phase;
`endif
                            if (timer == TIMER_ONE) begin
                                state       <= DONT_WALK;
                                flash_phase <= 1'b0;
                                dont_walk_q <= 1'b1;
                                countdown_q <= '0;
                            end else begin
                                timer       <= timer - TIMER_ONE;
                                countdown_q <= timer - TIMER_ONE;
                                flash_phase <= ~flash_phase;
                                dont_walk_q <= ~flash_phase;
                            end
                        end
                    end

                    default: begin
                        state       <= DONT_WALK;
                        walk_q      <= 1'b0;
                        dont_walk_q <= 1'b1;
                        countdown_q <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.walk        = walk_q;
    assign bus.dont_walk   = dont_walk_q;
    assign bus.countdown   = countdown_q;
    assign bus.req_pending = req_q;
    assign bus.fault       = fault_q;
`ifdef PED_ACCESSIBLE_EN
    assign bus.chirp       = chirp_q;
`else
    assign bus.chirp       = 1'b0;
`endif

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// tb/tb_ped_crossing_ctrl.sv - scoreboard bench for ped_crossing_ctrl (honours PED_ACCESSIBLE_EN)
module tb_ped_crossing_ctrl;

`ifdef PED_ACCESSIBLE_EN
    localparam int CH = 1;
`else
    localparam int CH = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ped_crossing_ctrl_if bus();

    ped_crossing_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // snap = {walk, dont_walk, countdown[3:0], req_pending, fault}
    typedef struct {
        logic [7:0] snap;
        int         ticks;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks     = 0;
    int         n_fail       = 0;
    int         ticks_seen   = 0;
    int         ticks_sent   = 0;
    int         chirp_pulses = 0;
    logic [7:0] last_snap    = 8'h40;
    logic       last_chirp   = 1'b0;

    function automatic logic [7:0] mk(input int w, input int d, input int c, input int r, input int f);
        return {1'(w), 1'(d), 4'(c), 1'(r), 1'(f)};
    endfunction

    // Expected output change; toff = ticks still to be issued before it appears.
    task automatic push(input int w, input int d, input int c, input int r, input int f, input int toff);
        exp_t e;
        e.snap  = mk(w, d, c, r, f);
        e.ticks = ticks_sent + toff;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        if (bus.tick === 1'b1) ticks_seen++;
    end

    // Monitor: every change of the output tuple consumes one expected entry.
    always @(negedge clk) begin : monitor
        logic [7:0] cur;
        exp_t       e;
        cur = {bus.walk, bus.dont_walk, bus.countdown, bus.req_pending, bus.fault};
        if (bus.chirp === 1'b1 && last_chirp !== 1'b1) chirp_pulses++;
        last_chirp = bus.chirp;
        if (cur !== last_snap) begin
            last_snap = cur;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_change: got outputs=%b ticks=%0d, required no change", cur, ticks_seen);
            end else begin
                e = exp_q.pop_front();
                if (cur !== e.snap || ticks_seen != e.ticks) begin
                    n_fail++;
                    $display("FAIL seq_check: got outputs=%b ticks=%0d, required outputs=%b ticks=%0d",
                             cur, ticks_seen, e.snap, e.ticks);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        bus.tick = 1'b1;
        step(1);
        bus.tick = 1'b0;
        ticks_sent++;
        step(3);
    endtask

    task automatic set_lights(input logic [2:0] l);
        bus.lights = l;
        step(3);
    endtask

    task automatic press(input int hold);
        bus.ped_btn = 1'b1;
        step(hold);
        bus.ped_btn = 1'b0;
        step(10);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            step(1);
            k++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: got %0d expected changes still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_chirp(input string name, input int expected);
        n_checks++;
        if (chirp_pulses != expected) begin
            n_fail++;
            $display("FAIL %s: got chirp pulses=%0d, required %0d", name, chirp_pulses, expected);
        end
    endtask

    task automatic check_now(input string name, input logic [8:0] expected);
        logic [8:0] cur;
        cur = {bus.walk, bus.dont_walk, bus.countdown, bus.req_pending, bus.fault, bus.chirp};
        n_checks++;
        if (cur !== expected) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b", name, cur, expected);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.tick    = 1'b0;
        bus.lights  = 3'b100;
        bus.ped_btn = 1'b0;
        rst         = 1'b1;
        step(3);
        check_now("reset_state", 9'b0_1_0000_0_0_0);
        rst = 1'b0;
        step(2);

        // Press while red already lit: latch only, no WALK.
        push(0, 1, 0, 1, 0, 0);
        press(6);
        step(5);
        drain("s1_press");
        set_lights(3'b001);
        set_lights(3'b010);
        push(1, 0, 0, 0, 0, 0);
        set_lights(3'b100);
        drain("s1_grant");

        // Full WALK (4 ticks) then CLEAR 5..1 with flashing.
        push(0, 1, 5, 0, 0, 4);
        push(0, 0, 4, 0, 0, 5);
        push(0, 1, 3, 0, 0, 6);
        push(0, 0, 2, 0, 0, 7);
        push(0, 1, 1, 0, 0, 8);
        push(0, 1, 0, 0, 0, 9);
        repeat (9) do_tick();
        drain("s1_walk_clear");
        check_chirp("chirp_full_cycle", 7 * CH);

        // Bouncing button: exactly one request.
        push(0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            bus.ped_btn = (i % 2 == 0);
            step(1);
        end
        bus.ped_btn = 1'b1;
        step(6);
        bus.ped_btn = 1'b0;
        step(12);
        drain("s2_bounce");

        // Grant, press during CLEAR, served next red.
        set_lights(3'b001);
        set_lights(3'b010);
        push(1, 0, 0, 0, 0, 0);
        set_lights(3'b100);
        push(0, 1, 5, 0, 0, 4);
        push(0, 0, 4, 0, 0, 5);
        repeat (5) do_tick();
        drain("s3_into_clear");
        push(0, 0, 4, 1, 0, 0);
        press(6);
        drain("s3_press_in_clear");
        push(0, 1, 3, 1, 0, 1);
        push(0, 0, 2, 1, 0, 2);
        push(0, 1, 1, 1, 0, 3);
        push(0, 1, 0, 1, 0, 4);
        repeat (4) do_tick();
        drain("s3_clear_done");
        check_chirp("chirp_second_cycle", 14 * CH);
        set_lights(3'b001);
        set_lights(3'b010);
        push(1, 0, 0, 0, 0, 0);
        set_lights(3'b100);
        drain("s3_regrant");
        press(6);
        repeat (2) do_tick();
        push(0, 1, 0, 0, 0, 0);
        set_lights(3'b001);
        drain("s3_premature_green");
        check_chirp("chirp_aborted_walk", 16 * CH);

        // Illegal lights during WALK: sticky fault, no further grants.
        push(0, 1, 0, 1, 0, 0);
        press(6);
        drain("s4_press");
        set_lights(3'b010);
        push(1, 0, 0, 0, 0, 0);
        set_lights(3'b100);
        drain("s4_grant");
        push(0, 1, 0, 0, 1, 0);
        bus.lights = 3'b110;
        step(1);
        bus.lights = 3'b100;
        step(3);
        drain("s4_fault");
        push(0, 1, 0, 1, 1, 0);
        press(6);
        drain("s4_press_in_fault");
        set_lights(3'b001);
        set_lights(3'b010);
        set_lights(3'b100);
        repeat (3) do_tick();
        step(4);
        check_chirp("chirp_fault", 16 * CH);
        push(0, 1, 0, 0, 0, 0);
        rst = 1'b1;
        step(2);
        drain("s4_reset_clears");
        rst = 1'b0;
        step(2);

        // Button rise in the same cycle as the grant is absorbed by it.
        push(0, 1, 0, 1, 0, 0);
        press(6);
        drain("s5_press");
        set_lights(3'b001);
        set_lights(3'b010);
        bus.ped_btn = 1'b1;
        step(6);
        push(1, 0, 0, 0, 0, 0);
        bus.lights = 3'b100;
        step(4);
        bus.ped_btn = 1'b0;
        step(12);
        drain("s5_simultaneous");
        push(0, 1, 0, 0, 0, 0);
        set_lights(3'b001);
        drain("s5_exit");
        step(10);
        check_now("final_state", 9'b0_1_0000_0_0_0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
